cprv_scoreboard: RTL and testbench

- Issue-control scoreboard between the ID stage and the EX stage of the cprv64g pipeline.
- Tracks architectural registers x1..x31 that have an outstanding write from an issued instruction that has not yet retired in WB.
- Gates the ID->EX handshake on RAW/WAW hazards and on an in-flight limit, and clears all state on a pipeline flush.
- Drives the ID stage's ready and qualifies its valid; the ID stage itself holds no hazard logic.

---
 rtl/cprv_scoreboard_if.sv | 35 +++
 rtl/cprv_scoreboard.sv | 98 +++++++++
 tb/tb_cprv_scoreboard.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cprv_scoreboard_if.sv
// Handshake and status bundle between the ID stage, the issue scoreboard and EX/WB.
// The scoreboard takes the slave view; the ID/WB-side driver takes the master view.
interface cprv_scoreboard_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 issue_valid_i;
    logic                 issue_ready_o;
    logic                 issue_fire_o;
    logic                 ex_ready_i;
    logic [4:0]           rs1_addr_i;
    logic                 rs1_use_i;
    logic [4:0]           rs2_addr_i;
    logic                 rs2_use_i;
    logic [4:0]           rd_addr_i;
    logic                 rd_en_i;
    logic                 retire_valid_i;
    logic [4:0]           retire_rd_addr_i;
    logic                 flush_i;
    logic [31:0]          pending_o;
    logic [3:0]           inflight_o;
    logic [CNT_WIDTH-1:0] stall_cnt_o;
    logic                 err_o;

    modport master (
        output issue_valid_i, ex_ready_i, rs1_addr_i, rs1_use_i, rs2_addr_i, rs2_use_i,
               rd_addr_i, rd_en_i, retire_valid_i, retire_rd_addr_i, flush_i,
        input  issue_ready_o, issue_fire_o, pending_o, inflight_o, stall_cnt_o, err_o
    );

    modport slave (
        input  issue_valid_i, ex_ready_i, rs1_addr_i, rs1_use_i, rs2_addr_i, rs2_use_i,
               rd_addr_i, rd_en_i, retire_valid_i, retire_rd_addr_i, flush_i,
        output issue_ready_o, issue_fire_o, pending_o, inflight_o, stall_cnt_o, err_o
    );
endinterface

// File: rtl/cprv_scoreboard.sv
// ID->EX issue scoreboard: tracks outstanding register writers and gates issue on
// RAW/WAW hazards and an in-flight limit; flush discards all outstanding writers.
module cprv_scoreboard #(
    parameter int MAX_INFLIGHT  = 4,
    parameter int CNT_WIDTH     = 32,
    parameter int RETIRE_BYPASS = 1
) (
    input logic              clk,
    input logic              rst,
    cprv_scoreboard_if.slave sb
);
    localparam bit         BYPASS  = (RETIRE_BYPASS != 0);
    localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

    logic [31:0]          pending;
    logic [3:0]           inflight;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic                 err;

    logic [31:0] clr_vec;
    logic [31:0] set_vec;
    logic [31:0] pend_eff;
    logic [31:0] pending_nxt;
    logic [3:0]  inflight_nxt;
    logic        raw;
    logic        waw;
    logic        full;
    logic        ready;
    logic        fire;
    logic        do_set;
    logic        retire_ok;
    logic        stall_inc;

    // A write-first regfile lets a same-cycle retire hide the hazard it resolves.
    always_comb begin
        clr_vec      = '0;
        set_vec      = '0;
        pending_nxt  = pending;
        inflight_nxt = inflight;

        if (sb.retire_valid_i && BYPASS)
            clr_vec[sb.retire_rd_addr_i] = 1'b1;
        pend_eff = pending & ~clr_vec;

        raw   = (sb.rs1_use_i && pend_eff[sb.rs1_addr_i]) ||
                (sb.rs2_use_i && pend_eff[sb.rs2_addr_i]);
        waw   = sb.rd_en_i && (sb.rd_addr_i != 5'd0) && pend_eff[sb.rd_addr_i];
        full  = sb.rd_en_i && (inflight == MAX_CNT) && !(sb.retire_valid_i && BYPASS);
        ready = sb.ex_ready_i && !sb.flush_i && !raw && !waw && !full;
        fire  = sb.issue_valid_i && ready;

        do_set = fire && sb.rd_en_i && (sb.rd_addr_i != 5'd0);
        if (do_set)
            set_vec[sb.rd_addr_i] = 1'b1;

        retire_ok = sb.retire_valid_i && (inflight != 4'd0) && pending[sb.retire_rd_addr_i];

        if (sb.flush_i) begin
            pending_nxt  = '0;
            inflight_nxt = '0;
        end else begin
            if (retire_ok)
                pending_nxt[sb.retire_rd_addr_i] = 1'b0;
            pending_nxt = pending_nxt | set_vec;
            case ({do_set, retire_ok})
                2'b10:   inflight_nxt = inflight + 4'd1;
                2'b01:   inflight_nxt = inflight - 4'd1;
                default: inflight_nxt = inflight;
            endcase
        end

        stall_inc = sb.issue_valid_i && sb.ex_ready_i && !sb.flush_i && !ready;
    end

    // Stall count and err survive a flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            inflight  <= '0;
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            inflight <= inflight_nxt;
            if (sb.retire_valid_i && !retire_ok)
                err <= 1'b1;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign sb.issue_ready_o = ready;
    assign sb.issue_fire_o  = fire;
    assign sb.pending_o     = pending;
    assign sb.inflight_o    = inflight;
    assign sb.stall_cnt_o   = stall_cnt;
    assign sb.err_o         = err;
endmodule

// File: tb/tb_cprv_scoreboard.sv
// Directed bench for cprv_scoreboard: two instances (bypass/limit 4, no-bypass/limit 2
// with a 3-bit stall counter) share one stimulus stream and are checked against a model.
module tb_cprv_scoreboard;
    localparam int NI = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, ex_ready, rs1_use, rs2_use, rd_en, retire_valid, flush;
    logic [4:0] rs1_addr, rs2_addr, rd_addr, retire_rd_addr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cprv_scoreboard_if #(.CNT_WIDTH(32)) sba ();
    cprv_scoreboard_if #(.CNT_WIDTH(3))  sbb ();

    assign sba.issue_valid_i    = issue_valid;
    assign sba.ex_ready_i       = ex_ready;
    assign sba.rs1_addr_i       = rs1_addr;
    assign sba.rs1_use_i        = rs1_use;
    assign sba.rs2_addr_i       = rs2_addr;
    assign sba.rs2_use_i        = rs2_use;
    assign sba.rd_addr_i        = rd_addr;
    assign sba.rd_en_i          = rd_en;
    assign sba.retire_valid_i   = retire_valid;
    assign sba.retire_rd_addr_i = retire_rd_addr;
    assign sba.flush_i          = flush;

    assign sbb.issue_valid_i    = issue_valid;
    assign sbb.ex_ready_i       = ex_ready;
    assign sbb.rs1_addr_i       = rs1_addr;
    assign sbb.rs1_use_i        = rs1_use;
    assign sbb.rs2_addr_i       = rs2_addr;
    assign sbb.rs2_use_i        = rs2_use;
    assign sbb.rd_addr_i        = rd_addr;
    assign sbb.rd_en_i          = rd_en;
    assign sbb.retire_valid_i   = retire_valid;
    assign sbb.retire_rd_addr_i = retire_rd_addr;
    assign sbb.flush_i          = flush;

    cprv_scoreboard #(.MAX_INFLIGHT(4), .CNT_WIDTH(32), .RETIRE_BYPASS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .sb  (sba.slave)
    );

    cprv_scoreboard #(.MAX_INFLIGHT(2), .CNT_WIDTH(3), .RETIRE_BYPASS(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .sb  (sbb.slave)
    );

    // Reference model: per-instance set of busy registers, writer count, stall count, error.
    int     p_max[NI] = '{4, 2};
    bit     p_byp[NI] = '{1'b1, 1'b0};
    longint p_sat[NI] = '{64'hFFFF_FFFF, 64'd7};

    bit     m_pend[NI][32];
    int     m_infl[NI];
    longint m_stall[NI];
    bit     m_err[NI];

    function automatic bit m_busy(int k, int r);
        return (r != 0) && m_pend[k][r] &&
               !(retire_valid && p_byp[k] && (int'(retire_rd_addr) == r));
    endfunction

    function automatic bit m_ready(int k);
        bit hazard;
        bit full;
        hazard = (rs1_use && m_busy(k, int'(rs1_addr))) ||
                 (rs2_use && m_busy(k, int'(rs2_addr))) ||
                 (rd_en   && m_busy(k, int'(rd_addr)));
        full   = rd_en && (m_infl[k] == p_max[k]) && !(retire_valid && p_byp[k]);
        return ex_ready && !flush && !hazard && !full;
    endfunction

    function automatic logic [31:0] m_pend_word(int k);
        logic [31:0] w;
        w = '0;
        for (int r = 1; r < 32; r++)
            w[r] = m_pend[k][r];
        return w;
    endfunction

    task automatic model_step(int k);
        bit fire, wr, ret_ok;
        fire   = issue_valid && m_ready(k);
        wr     = fire && rd_en && (rd_addr != 5'd0);
        ret_ok = retire_valid && (m_infl[k] > 0) && m_pend[k][retire_rd_addr];
        if (retire_valid && !ret_ok)
            m_err[k] = 1'b1;
        if (issue_valid && ex_ready && !flush && !m_ready(k) && (m_stall[k] < p_sat[k]))
            m_stall[k] = m_stall[k] + 1;
        if (flush) begin
            for (int r = 0; r < 32; r++)
                m_pend[k][r] = 1'b0;
            m_infl[k] = 0;
        end else begin
            if (ret_ok) begin
                m_pend[k][retire_rd_addr] = 1'b0;
                m_infl[k] = m_infl[k] - 1;
            end
            if (wr) begin
                m_pend[k][rd_addr] = 1'b1;
                m_infl[k] = m_infl[k] + 1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                for (int r = 0; r < 32; r++)
                    m_pend[k][r] = 1'b0;
                m_infl[k]  = 0;
                m_stall[k] = 0;
                m_err[k]   = 1'b0;
            end
        end else begin
            for (int k = 0; k < NI; k++)
                model_step(k);
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic check_inst(input int k, input string tag, input logic rdy, input logic fr,
                              input logic [31:0] pend, input logic [3:0] infl,
                              input longint stall, input logic err);
        checkOutput({tag, "_ready"},    longint'(rdy),  longint'(m_ready(k)));
        checkOutput({tag, "_fire"},     longint'(fr),   longint'(issue_valid && m_ready(k)));
        checkOutput({tag, "_pending"},  longint'(pend), longint'(m_pend_word(k)));
        checkOutput({tag, "_inflight"}, longint'(infl), longint'(m_infl[k]));
        checkOutput({tag, "_stall"},    stall,          m_stall[k]);
        checkOutput({tag, "_err"},      longint'(err),  longint'(m_err[k]));
    endtask

    // Every cycle, mid-period, both instances are compared against the model.
    always @(negedge clk) begin
        check_inst(0, "a", sba.issue_ready_o, sba.issue_fire_o, sba.pending_o,
                   sba.inflight_o, longint'(sba.stall_cnt_o), sba.err_o);
        check_inst(1, "b", sbb.issue_ready_o, sbb.issue_fire_o, sbb.pending_o,
                   sbb.inflight_o, longint'(sbb.stall_cnt_o), sbb.err_o);
    end

    task automatic applyStimulus(input bit v, input int rs1, input bit u1, input int rs2,
                                 input bit u2, input int rd, input bit we, input bit rv,
                                 input int rrd, input bit fl);
        issue_valid    = v;
        rs1_addr       = 5'(rs1);
        rs1_use        = u1;
        rs2_addr       = 5'(rs2);
        rs2_use        = u2;
        rd_addr        = 5'(rd);
        rd_en          = we;
        retire_valid   = rv;
        retire_rd_addr = 5'(rrd);
        flush          = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst      = 1'b1;
        ex_ready = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        settle();
        checkOutput("rst_a_ready",    longint'(sba.issue_ready_o), 1);
        checkOutput("rst_b_ready",    longint'(sbb.issue_ready_o), 1);
        checkOutput("rst_a_pending",  longint'(sba.pending_o),     0);
        checkOutput("rst_a_inflight", longint'(sba.inflight_o),    0);
        checkOutput("rst_a_stall",    longint'(sba.stall_cnt_o),   0);
        checkOutput("rst_b_err",      longint'(sbb.err_o),         0);
        step();

        // ADD x5 issues immediately, x5 becomes busy next cycle
        rst = 1'b0;
        applyStimulus(1, 0, 1, 0, 1, 5, 1, 0, 0, 0);
        settle();
        checkOutput("t1_a_fire", longint'(sba.issue_fire_o), 1);
        checkOutput("t1_b_fire", longint'(sbb.issue_fire_o), 1);
        step();

        // reader of x5 stalls until x5 retires
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("t2_a_pending",  longint'(sba.pending_o),     32'h20);
        checkOutput("t2_a_inflight", longint'(sba.inflight_o),    1);
        checkOutput("t2_b_pending",  longint'(sbb.pending_o),     32'h20);
        checkOutput("t2_a_ready",    longint'(sba.issue_ready_o), 0);
        step();
        step();
        step();
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
        settle();
        checkOutput("t2_a_stall",     longint'(sba.stall_cnt_o),  3);
        checkOutput("t2_b_stall",     longint'(sbb.stall_cnt_o),  3);
        checkOutput("t2_a_fire_byp",  longint'(sba.issue_fire_o), 1);
        checkOutput("t2_b_fire_nobp", longint'(sbb.issue_fire_o), 0);
        step();
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("t2_b_fire_late", longint'(sbb.issue_fire_o), 1);
        checkOutput("t2_b_pending",   longint'(sbb.pending_o),    0);
        checkOutput("t2_b_stall4",    longint'(sbb.stall_cnt_o),  4);
        checkOutput("t2_a_stall3",    longint'(sba.stall_cnt_o),  3);
        step();

        // in-flight limit on instance b (limit 2)
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        settle();
        checkOutput("t3_b_full",  longint'(sbb.issue_ready_o), 0);
        checkOutput("t3_a_ready", longint'(sba.issue_ready_o), 1);
        step();
        step();
        step();
        step();
        step();
        settle();
        checkOutput("t3_b_stall_sat", longint'(sbb.stall_cnt_o), 7);
        checkOutput("t3_a_stall",     longint'(sba.stall_cnt_o), 7);
        applyStimulus(1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("t3_b_nonwriter_fire", longint'(sbb.issue_fire_o), 1);
        step();

        // issue and retire x7 in the same cycle keeps x7 busy
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
        settle();
        checkOutput("t4_a_fire", longint'(sba.issue_fire_o), 1);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("t4_a_pending",  longint'(sba.pending_o),  32'h8E);
        checkOutput("t4_a_inflight", longint'(sba.inflight_o), 4);
        checkOutput("t4_b_err",      longint'(sbb.err_o),      1);
        checkOutput("t4_b_pending",  longint'(sbb.pending_o),  32'h06);
        checkOutput("t4_b_inflight", longint'(sbb.inflight_o), 2);

        rst = 1'b1;
        settle();
        checkOutput("t5_rst_a_inflight", longint'(sba.inflight_o), 0);
        checkOutput("t5_rst_b_err",      longint'(sbb.err_o),      0);
        step();

        // build pending 0x26 on instance a, then flush with an issue pending
        rst = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step();
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 8, 1, 0, 0, 1);
        settle();
        checkOutput("t5_a_pending",  longint'(sba.pending_o),    32'h26);
        checkOutput("t5_a_inflight", longint'(sba.inflight_o),   3);
        checkOutput("t5_a_fire",     longint'(sba.issue_fire_o), 0);
        checkOutput("t5_b_fire",     longint'(sbb.issue_fire_o), 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("t5_a_pending0",  longint'(sba.pending_o),   0);
        checkOutput("t5_a_inflight0", longint'(sba.inflight_o),  0);
        checkOutput("t5_a_stall",     longint'(sba.stall_cnt_o), 1);
        checkOutput("t5_b_stall",     longint'(sbb.stall_cnt_o), 2);
        checkOutput("t5_b_pending0",  longint'(sbb.pending_o),   0);

        // retire of a non-pending register raises a sticky error
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checkOutput("t6_a_err",      longint'(sba.err_o),      1);
        checkOutput("t6_a_pending",  longint'(sba.pending_o),  32'h2);
        checkOutput("t6_a_inflight", longint'(sba.inflight_o), 1);
        step();
        step();
        settle();
        checkOutput("t6_a_err_sticky", longint'(sba.err_o), 1);

        // reset asserted in the middle of a stall
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst = 1'b1;
        settle();
        checkOutput("t7_a_pending",  longint'(sba.pending_o),     0);
        checkOutput("t7_a_inflight", longint'(sba.inflight_o),    0);
        checkOutput("t7_a_stall",    longint'(sba.stall_cnt_o),   0);
        checkOutput("t7_a_err",      longint'(sba.err_o),         0);
        checkOutput("t7_a_ready",    longint'(sba.issue_ready_o), 1);
        checkOutput("t7_a_fire",     longint'(sba.issue_fire_o),  1);
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
